// File: rtl/cla_pkg.sv
// Shared constants and lookahead helpers for the pipelined carry-lookahead add/sub unit.
package cla_pkg;

   localparam logic OP_ADD  = 1'b0;
   localparam logic OP_SUB  = 1'b1;
   localparam int   MAX_GRP = 8;

   function automatic bit cfg_ok(input int width, input int group);
      return (group > 0) && ((width % group) == 0) &&
             ((width / group) >= 1) && ((width / group) <= MAX_GRP);
   endfunction

   // Inter-group carries as a flat sum of products: C[k+1] = GG[k] | GP[k]&C[k] fully expanded.
   function automatic logic [MAX_GRP:0] lookahead_carries(input logic [MAX_GRP-1:0] gg,
                                                          input logic [MAX_GRP-1:0] gp,
                                                          input logic             cin);
      logic [MAX_GRP:0] c;
      logic             term;
      c    = '0;
      c[0] = cin;
      for (int k = 0; k < MAX_GRP; k++) begin
         term = cin;
         for (int j = 0; j <= k; j++) term = term & gp[j];
         c[k+1] = term;
         for (int j = 0; j <= k; j++) begin
            term = gg[j];
            for (int m = j + 1; m <= k; m++) term = term & gp[m];
            c[k+1] = c[k+1] | term;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit carry-lookahead cell: flat internal carries, group sum and group generate/propagate.
module cla_group #(
   parameter int GROUP = 5
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             cin,
   output logic [GROUP-1:0] sum,
   output logic             gg,
   output logic             gp
);

   logic [GROUP-1:0] g;
   logic [GROUP-1:0] p;
   logic [GROUP-1:0] c;
   logic             term;

   assign g = a & b;
   assign p = a ^ b;

   always_comb begin
      term = 1'b0;
      c    = '0;
      for (int i = 0; i < GROUP; i++) begin
         c[i] = cin;
         for (int j = 0; j < i; j++) c[i] = c[i] & p[j];
         for (int j = 0; j < i; j++) begin
            term = g[j];
            for (int m = j + 1; m < i; m++) term = term & p[m];
            c[i] = c[i] | term;
         end
      end
      // Group generate is the carry out of the top bit with no carry coming in.
      gg = 1'b0;
      for (int j = 0; j < GROUP; j++) begin
         term = g[j];
         for (int m = j + 1; m < GROUP; m++) term = term & p[m];
         gg = gg | term;
      end
   end

   assign gp  = &p;
   assign sum = p ^ c;

endmodule

// File: rtl/cla_pipe_addsub.sv
// Two-stage pipelined carry-lookahead adder/subtractor with carry, overflow and zero flags.
module cla_pipe_addsub
   import cla_pkg::*;
#(
   parameter int WIDTH = 20,
   parameter int GROUP = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int NGRP = WIDTH / GROUP;
   localparam int NC   = NGRP + 1;

   if (!cfg_ok(WIDTH, GROUP)) begin : g_bad_cfg
      $error("cla_pipe_addsub: WIDTH must be a multiple of GROUP giving 1..8 groups");
   end

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] s1_sum_unused;
   logic [NGRP-1:0]  gg_d, gp_d;
   logic             s1_valid;
   logic [WIDTH-1:0] s1_g, s1_p;
   logic [NGRP-1:0]  s1_gg, s1_gp;
   logic             s1_cin, s1_a_msb, s1_b_msb;
   logic             accept, s2_load;
   logic [NGRP:0]    carry;
   logic [WIDTH-1:0] sum_d;
   logic [NGRP-1:0]  s2_gg_unused, s2_gp_unused;

   // Handshake: a beat moves when valid && ready on a clk edge; S1 drains into the output
   // register whenever that register is empty or being popped, so a push and a pop can share a cycle.
   assign s2_load  = s1_valid && (!out_valid || out_ready);
   assign in_ready = !s1_valid || s2_load;
   assign accept   = in_valid && in_ready;

   assign b_eff = (in_op == OP_SUB) ? ~in_b : in_b;
   assign carry = NC'(lookahead_carries(MAX_GRP'(s1_gg), MAX_GRP'(s1_gp), s1_cin));

   for (genvar k = 0; k < NGRP; k++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_s1 (
         .a   (in_a[k*GROUP +: GROUP]),
         .b   (b_eff[k*GROUP +: GROUP]),
         .cin (1'b0),
         .sum (s1_sum_unused[k*GROUP +: GROUP]),
         .gg  (gg_d[k]),
         .gp  (gp_d[k])
      );
      // (g|p, g) regenerates exactly the registered g and p inside the cell.
      cla_group #(.GROUP(GROUP)) u_s2 (
         .a   (s1_g[k*GROUP +: GROUP] | s1_p[k*GROUP +: GROUP]),
         .b   (s1_g[k*GROUP +: GROUP]),
         .cin (carry[k]),
         .sum (sum_d[k*GROUP +: GROUP]),
         .gg  (s2_gg_unused[k]),
         .gp  (s2_gp_unused[k])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
      end else if (accept) begin
         s1_valid <= 1'b1;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         s1_g     <= in_a & b_eff;
         s1_p     <= in_a ^ b_eff;
         s1_gg    <= gg_d;
         s1_gp    <= gp_d;
         s1_cin   <= in_cin;
         s1_a_msb <= in_a[WIDTH-1];
         s1_b_msb <= b_eff[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
         out_zero  <= 1'b0;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         out_sum   <= sum_d;
         out_cout  <= carry[NGRP];
         out_ovf   <= (s1_a_msb == s1_b_msb) && (sum_d[WIDTH-1] != s1_a_msb);
         out_zero  <= (sum_d == '0);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
